// File: rtl/button_event_arbiter.sv
// Push-button front end: per-line synchroniser + edge latch, round-robin offer with hold-off.
// Optional BEA_DROP_COUNT_EN adds a saturating drop_cnt output.

module button_event_lane #(
  parameter int SYNC_N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic clr,
  output logic pending,
  output logic drop
);
  logic [SYNC_N-1:0] sync_q;
  logic              edge_q;
  logic              pulse;

  assign pulse = sync_q[SYNC_N-1] & ~edge_q;
  // A fresh edge on a line that stays pending is lost.
  assign drop  = pulse & pending & ~clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_N-2:0], btn};
      edge_q  <= sync_q[SYNC_N-1];
      pending <= pulse | (pending & ~clr);
    end
  end
endmodule

module button_event_arbiter #(
  parameter int N       = 4,
  parameter int SYNC_N  = 2,
  parameter int HOLDOFF = 4,
  localparam int IW     = $clog2(N),
  localparam int CW     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  btn,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [N-1:0]  ev_onehot,
  output logic [IW-1:0] ev_idx,
  output logic [N-1:0]  pending,
  output logic          overflow
`ifdef BEA_DROP_COUNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last, last_nxt, idx_nxt, sel_idx;
  logic [N-1:0]  oh_nxt, clr, drop;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          hs;
  int            j;

  button_event_lane #(.SYNC_N(SYNC_N)) u_lane [N-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .clr    (clr),
    .pending(pending),
    .drop   (drop)
  );

  assign ev_valid = (state == OFFER);
  assign clr      = hs ? ev_onehot : '0;

  // Round robin: scan from last+1 upward with wrap, first pending line wins.
  always_comb begin
    sel_idx = '0;
    j       = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (pending[j]) sel_idx = IW'(j);
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    idx_nxt   = ev_idx;
    oh_nxt    = ev_onehot;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_nxt = OFFER;
          idx_nxt   = sel_idx;
          oh_nxt    = N'(1) << sel_idx;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          hs        = 1'b1;
          state_nxt = HOLD;
          last_nxt  = ev_idx;
          cnt_nxt   = CW'(HOLDOFF - 1);
          idx_nxt   = '0;
          oh_nxt    = '0;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if (|pending) begin
            state_nxt = OFFER;
            idx_nxt   = sel_idx;
            oh_nxt    = N'(1) << sel_idx;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IW'(N - 1);
      cnt       <= '0;
      ev_idx    <= '0;
      ev_onehot <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      ev_idx    <= idx_nxt;
      ev_onehot <= oh_nxt;
      overflow  <= overflow | (|drop);
    end
  end

`ifdef BEA_DROP_COUNT_EN
  logic [3:0] n_drop;
  logic [8:0] dsum;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N; i++) n_drop = n_drop + 4'(drop[i]);
  end

  assign dsum = {1'b0, drop_cnt} + 9'(n_drop);

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= dsum[8] ? 8'hFF : dsum[7:0];
  end
`endif
endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter (N=4, SYNC_N=2, HOLDOFF=4).
module tb_button_event_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = '0;
  logic       ev_valid, ev_ready = 1'b0, overflow;
  logic [3:0] ev_onehot, pending;
  logic [1:0] ev_idx;
`ifdef BEA_DROP_COUNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_chk = 0, n_err = 0, cyc = 0, hs_cnt = 0;
  int exp_q[$];

  button_event_arbiter #(.N(4), .SYNC_N(2), .HOLDOFF(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_onehot(ev_onehot),
    .ev_idx   (ev_idx),
    .pending  (pending),
    .overflow (overflow)
`ifdef BEA_DROP_COUNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Handshakes are sampled mid-cycle; each one must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("sb_unexpected_ev", exp_q.size(), 1);
      else begin
        int e;
        e = exp_q.pop_front();
        chk("sb_idx", int'(ev_idx), e);
        chk("sb_onehot", int'(ev_onehot), 1 << e);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!ev_valid && k < 40) begin
      step();
      k++;
    end
    if (!ev_valid) chk(tag, ev_valid, 1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      step();
      k++;
    end
    step(6);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int t0, h0;
    // reset state
    step(3);
    chk("rst_valid", ev_valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_onehot", ev_onehot, 0);
    chk("rst_idx", ev_idx, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    // T1: single press, latency and no repeat while held
    ev_ready = 1'b1;
    step(10);
    btn[2] = 1'b1;
    exp_q.push_back(2);
    step(3);
    chk("t1_pending_set", pending, 4'b0100);
    chk("t1_valid_early", ev_valid, 0);
    step();
    chk("t1_valid", ev_valid, 1);
    chk("t1_onehot", ev_onehot, 4'b0100);
    chk("t1_idx", ev_idx, 2);
    step();
    chk("t1_valid_drop", ev_valid, 0);
    chk("t1_pending_clr", pending, 0);
    step(20);
    chk("t1_one_ev", hs_cnt, 1);
    btn = '0;
    drain("t1_drain");

    // T2: all buttons at once, fixed-order drain 5 cycles apart
    do_reset();
    btn = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid("t2_timeout");
      chk("t2_pending", pending, (4'b1111 << i) & 4'b1111);
      if (i > 0) chk("t2_gap", cyc - t0, 5);
      t0 = cyc;
      step();
    end
    chk("t2_pending_end", pending, 0);
    btn = '0;
    drain("t2_drain");

    // T3: double press while offer stalls -> overflow, single handshake
    do_reset();
    ev_ready = 1'b0;
    h0 = hs_cnt;
    btn[1] = 1'b1; step(2);
    btn[1] = 1'b0; step(2);
    btn[1] = 1'b1;
    exp_q.push_back(1);
    step(10);
    chk("t3_valid_held", ev_valid, 1);
    chk("t3_idx_held", ev_idx, 1);
    chk("t3_overflow", overflow, 1);
`ifdef BEA_DROP_COUNT_EN
    chk("t3_drop_cnt", drop_cnt, 1);
`endif
    ev_ready = 1'b1;
    step(15);
    chk("t3_one_hs", hs_cnt - h0, 1);
    chk("t3_pending", pending, 0);
    btn = '0;
    drain("t3_drain");

    // T4: round-robin after last=0 prefers 1 over 3
    do_reset();
    ev_ready = 1'b0;
    btn[0] = 1'b1;
    exp_q.push_back(0);
    wait_valid("t4_timeout");
    btn = 4'b1011;
    step(6);
    chk("t4_pending", pending, 4'b1011);
    chk("t4_idx_stable", ev_idx, 0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    ev_ready = 1'b1;
    drain("t4_drain");
    btn = '0;
    step(8);

    // T5: reset during HOLD discards everything
    do_reset();
    ev_ready = 1'b1;
    btn = 4'b0111;
    exp_q.push_back(0);
    wait_valid("t5_timeout");
    step(2);
    chk("t5_hold_valid", ev_valid, 0);
    chk("t5_hold_pending", pending, 4'b0110);
    rst_n = 1'b0;
    btn = '0;
    step();
    rst_n = 1'b1;
    chk("t5_rst_pending", pending, 0);
    chk("t5_rst_valid", ev_valid, 0);
    chk("t5_rst_onehot", ev_onehot, 0);
    chk("t5_rst_idx", ev_idx, 0);
    h0 = hs_cnt;
    step(15);
    chk("t5_no_ev", hs_cnt - h0, 0);
    btn[2] = 1'b1;
    exp_q.push_back(2);
    drain("t5_fresh_edge");
    btn = '0;
    step(8);

    // T6: button held through reset -> exactly one event
    rst_n = 1'b0;
    btn = 4'b0001;
    step(2);
    h0 = hs_cnt;
    rst_n = 1'b1;
    exp_q.push_back(0);
    step(30);
    chk("t6_one_ev", hs_cnt - h0, 1);
    chk("t6_sb_empty", exp_q.size(), 0);
    chk("t6_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
